// File: rtl/hash_match_stage.sv
// hash_match_stage: last stage of the lookup pipeline.
// Compares the delayed query key against every way of the bucket word. Hit/miss
// results go into a first-word-fall-through FIFO. The FIFO stalls the upstream
// delay lines through pipe_en_o. Saturating hit/miss statistics are also kept.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid, in_key  delayed query aligned with mem_rdata
//   mem_rdata         WAYS x {valid, key, value}, way i at [(i+1)*ENTRY_W-1 -: ENTRY_W]
//   pipe_en_o         1 = stage can accept a query (upstream write enable)
//   out_valid/ready   result handshake; out_* show the FIFO head, 0 when empty
//   out_hit, out_multi, out_way, out_key, out_value  result fields
//   stat_clr          clears hit_cnt/miss_cnt (wins over a coincident push)
//   hit_cnt, miss_cnt saturating statistics counters
module hash_match_stage #(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned VALUE_WIDTH = 32,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    input  logic [KEY_WIDTH-1:0]                          in_key,
    input  logic [WAYS*(1+KEY_WIDTH+VALUE_WIDTH)-1:0]     mem_rdata,
    output logic                                          pipe_en_o,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_hit,
    output logic                                          out_multi,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    out_way,
    output logic [KEY_WIDTH-1:0]                          out_key,
    output logic [VALUE_WIDTH-1:0]                        out_value,
    input  logic                                          stat_clr,
    output logic [31:0]                                   hit_cnt,
    output logic [31:0]                                   miss_cnt
);

    localparam int unsigned ENTRY_W = 1 + KEY_WIDTH + VALUE_WIDTH;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RES_W   = 2 + WAY_W + KEY_WIDTH + VALUE_WIDTH;

    logic [ENTRY_W-1:0]     way_entry [WAYS];
    logic [WAYS-1:0]        match;
    logic                   cmp_hit;
    logic                   cmp_multi;
    logic [WAY_W-1:0]       cmp_way;
    logic [VALUE_WIDTH-1:0] cmp_value;

    logic [RES_W-1:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [RES_W-1:0]       head;
    logic                   push;
    logic                   pop;

    // Per-way compare; first match wins, any further match flags multi.
    always_comb begin
        match     = '0;
        cmp_hit   = 1'b0;
        cmp_multi = 1'b0;
        cmp_way   = '0;
        cmp_value = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            way_entry[i] = mem_rdata[i*ENTRY_W +: ENTRY_W];
            match[i]     = way_entry[i][ENTRY_W-1] &&
                           (way_entry[i][ENTRY_W-2 -: KEY_WIDTH] == in_key);
            if (match[i]) begin
                if (cmp_hit) begin
                    cmp_multi = 1'b1;
                end else begin
                    cmp_hit   = 1'b1;
                    cmp_way   = WAY_W'(i);
                    cmp_value = way_entry[i][VALUE_WIDTH-1:0];
                end
            end
        end
    end

    // Accept only from the registered occupancy, so out_ready never reaches pipe_en_o.
    assign pipe_en_o = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && pipe_en_o;
    assign pop       = out_valid && out_ready;

    // Result storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmp_hit, cmp_multi, cmp_way, in_key, cmp_value};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation, forced to zero when empty.
    assign head      = fifo_mem[rd_ptr];
    assign out_hit   = out_valid & head[RES_W-1];
    assign out_multi = out_valid & head[RES_W-2];
    assign out_way   = out_valid ? head[VALUE_WIDTH+KEY_WIDTH +: WAY_W] : '0;
    assign out_key   = out_valid ? head[VALUE_WIDTH +: KEY_WIDTH] : '0;
    assign out_value = out_valid ? head[VALUE_WIDTH-1:0] : '0;

    // Statistics count accepted queries; a clear beats a coincident push.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (push) begin
            if (cmp_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hash_match_stage.sv
// tb_hash_match_stage: directed, table-driven bench for hash_match_stage
// (default parameters: 32-bit key/value, 4 ways, depth 4).
module tb_hash_match_stage;

    localparam int unsigned EW = 65;
    localparam int unsigned MW = 4 * EW;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_key;
    logic [MW-1:0] mem_rdata;
    logic          pipe_en_o;
    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic          out_multi;
    logic [1:0]    out_way;
    logic [31:0]   out_key;
    logic [31:0]   out_value;
    logic          stat_clr;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    hash_match_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_key    (in_key),
        .mem_rdata (mem_rdata),
        .pipe_en_o (pipe_en_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_multi (out_multi),
        .out_way   (out_way),
        .out_key   (out_key),
        .out_value (out_value),
        .stat_clr  (stat_clr),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   key;
        logic [MW-1:0] rdata;
        logic          hit;
        logic          multi;
        logic [1:0]    way;
        logic [31:0]   value;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [EW-1:0] ent(input logic v, input logic [31:0] k, input logic [31:0] val);
        return {v, k, val};
    endfunction

    function automatic logic [MW-1:0] word(input logic [EW-1:0] e3, input logic [EW-1:0] e2,
                                           input logic [EW-1:0] e1, input logic [EW-1:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats();
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_key"}, 64'(out_key), 64'd0);
        chk({tag, " out_value"}, 64'(out_value), 64'd0);
        chk({tag, " out_hit"}, 64'(out_hit), 64'd0);
        chk({tag, " pipe_en_o"}, 64'(pipe_en_o), 64'd1);
    endtask

    initial begin
        logic [MW-1:0] zw;
        zw = '0;

        // {key, rdata, hit, multi, way, value}
        vecs[0] = '{32'hABCD, word('0, ent(1'b1, 32'hABCD, 32'h55), '0, '0), 1'b1, 1'b0, 2'd2, 32'h55};
        vecs[1] = '{32'hABCD, word('0, '0, ent(1'b0, 32'hABCD, 32'h77), ent(1'b1, 32'h1234, 32'h1)),
                    1'b0, 1'b0, 2'd0, 32'h0};
        vecs[2] = '{32'h10, word(ent(1'b1, 32'h10, 32'hA3), '0, ent(1'b1, 32'h10, 32'hA1), '0),
                    1'b1, 1'b1, 2'd1, 32'hA1};
        vecs[3] = '{32'hDEAD, word('0, '0, '0, ent(1'b1, 32'hDEAD, 32'h99)), 1'b1, 1'b0, 2'd0, 32'h99};
        vecs[4] = '{32'h7, word(ent(1'b1, 32'h7, 32'h33), ent(1'b1, 32'h6, 32'h22), '0, '0),
                    1'b1, 1'b0, 2'd3, 32'h33};
        vecs[5] = '{32'h8000_0001, word(ent(1'b1, 32'h1, 32'h4), ent(1'b1, 32'h8000_0000, 32'h3),
                    ent(1'b1, 32'h0000_0001, 32'h2), ent(1'b1, 32'hFFFF_FFFF, 32'h1)),
                    1'b0, 1'b0, 2'd0, 32'h0};
        vecs[6] = '{32'h0, word('0, ent(1'b1, 32'h0, 32'hFFFF_FFFF), '0, ent(1'b0, 32'h0, 32'h5)),
                    1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_key    = '0;
        mem_rdata = zw;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        step();
        reset = 1'b0;

        // Reset state
        chk_empty("reset");
        chk("reset out_way", 64'(out_way), 64'd0);
        chk("reset out_multi", 64'(out_multi), 64'd0);
        chk_stats();

        // Single-query vectors: accept, check result next cycle, pop
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            in_key    = vecs[i].key;
            mem_rdata = vecs[i].rdata;
            step();
            in_valid = 1'b0;
            if (vecs[i].hit) exp_hits++;
            else             exp_misses++;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d out_hit", i), 64'(out_hit), 64'(vecs[i].hit));
            chk($sformatf("v%0d out_multi", i), 64'(out_multi), 64'(vecs[i].multi));
            chk($sformatf("v%0d out_way", i), 64'(out_way), 64'(vecs[i].way));
            chk($sformatf("v%0d out_value", i), 64'(out_value), 64'(vecs[i].value));
            chk($sformatf("v%0d out_key", i), 64'(out_key), 64'(vecs[i].key));
            chk_stats();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d popped", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: fill four, stall three cycles, then drain in order
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp pipe_en before push %0d", i), 64'(pipe_en_o), 64'd1);
            in_valid  = 1'b1;
            in_key    = 32'h300 + 32'(i);
            mem_rdata = word('0, '0, '0, ent(1'b1, 32'h300 + 32'(i), 32'h400 + 32'(i)));
            step();
            exp_hits++;
        end
        chk("bp pipe_en full", 64'(pipe_en_o), 64'd0);
        in_key    = 32'h3FF;
        mem_rdata = word('0, '0, '0, ent(1'b1, 32'h3FF, 32'h4FF));
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp stall %0d pipe_en", i), 64'(pipe_en_o), 64'd0);
            chk($sformatf("bp stall %0d head", i), 64'(out_key), 64'h300);
        end
        chk_stats();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp drain %0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp drain %0d key", i), 64'(out_key), 64'(32'h300 + 32'(i)));
            chk($sformatf("bp drain %0d value", i), 64'(out_value), 64'(32'h400 + 32'(i)));
            step();
            chk($sformatf("bp drain %0d pipe_en", i), 64'(pipe_en_o), 64'd1);
        end
        chk("bp drained", 64'(out_valid), 64'd0);

        // Streaming push+pop for 20 queries; stat_clr coincides with query 10
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1;
            in_key   = 32'h1000 + 32'(j);
            if (j % 2 == 0) begin
                mem_rdata = zw;
                mem_rdata[(j % 4) * EW +: EW] = ent(1'b1, 32'h1000 + 32'(j), 32'h200 + 32'(j));
            end else begin
                mem_rdata = word(ent(1'b0, 32'h1000 + 32'(j), 32'h1), ent(1'b1, 32'h2000, 32'h2), '0, '0);
            end
            stat_clr = (j == 10);
            step();
            stat_clr = 1'b0;
            if (j == 10) begin
                exp_hits   = 0;
                exp_misses = 0;
            end else if (j % 2 == 0) begin
                exp_hits++;
            end else begin
                exp_misses++;
            end
            chk($sformatf("st%0d valid", j), 64'(out_valid), 64'd1);
            chk($sformatf("st%0d pipe_en", j), 64'(pipe_en_o), 64'd1);
            chk($sformatf("st%0d key", j), 64'(out_key), 64'(32'h1000 + 32'(j)));
            chk($sformatf("st%0d hit", j), 64'(out_hit), 64'(j % 2 == 0));
            chk($sformatf("st%0d way", j), 64'(out_way), (j % 2 == 0) ? 64'(j % 4) : 64'd0);
            chk($sformatf("st%0d value", j), 64'(out_value), (j % 2 == 0) ? 64'(32'h200 + 32'(j)) : 64'd0);
            chk_stats();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk_empty("stream end");
        chk_stats();

        // Reset drops queued results and clears statistics
        in_valid  = 1'b1;
        in_key    = 32'h55AA;
        mem_rdata = word(ent(1'b1, 32'h55AA, 32'h9), '0, '0, '0);
        step();
        step();
        in_valid = 1'b0;
        chk("pre-reset valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        chk_empty("mid reset");
        chk_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
